mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4: fixed main-memory read latency in cycles, from mem_en to mem_rdata valid; legal range 1..8.
REQ-002 Parameter WORDS, default 8: 16-bit words per cache block; fixed at 8, giving a 16-byte block.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_req  in  1  instruction-cache miss; a level request, held until i_done.
REQ-006 i_addr  in  16  instruction miss address.
REQ-007 d_req  in  1  data-cache access request; a level request, held until d_done.
REQ-008 d_wr  in  1  qualifies d_req: 1 = single-word write-through, 0 = block fill.
REQ-009 d_addr  in  16  data address.
REQ-010 d_wdata  in  16  data write word.
REQ-011 mem_rdata  in  16  main-memory read data; valid exactly LATENCY cycles after a read issue.
REQ-012 mem_en  out  1  memory access strobe, one access per cycle.
REQ-013 mem_wr  out  1  memory write qualifier.
REQ-014 mem_addr  out  16  memory word address.
REQ-015 mem_wdata  out  16  memory write data.
REQ-016 fill_data  out  16  returned word, equal to mem_rdata.
REQ-017 fill_idx  out  3  block word index of fill_data.
REQ-018 i_data_valid / d_data_valid  out  1 each  fill_data belongs to the I-side / D-side fill.
REQ-019 i_busy / d_busy  out  1 each  the I-side / D-side transaction is in progress.
REQ-020 i_done / d_done  out  1 each  one-cycle completion pulse.

Function
REQ-021 The controller SHALL be a state machine with the states IDLE, D_WRITE, D_FILL and I_FILL.
REQ-022 In IDLE the grant SHALL be evaluated every cycle with this priority: d_req&d_wr, then d_req&~d_wr, then i_req.
  - D_WRITE is entered for d_req&d_wr.
  - D_FILL is entered for d_req&~d_wr.
  - I_FILL is entered for i_req.
  - D beats I when both request in the same cycle.
REQ-023 On a grant the arbiter SHALL latch the block base, addr & 16'hFFF0, and SHALL ignore later address changes until done.
REQ-024 D_WRITE SHALL be one cycle.
  - Outputs that cycle: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata.
  - d_done pulses in that same cycle.
  - The next state is IDLE.
REQ-025 A fill SHALL issue reads on WORDS consecutive cycles, issue k = 0..7, with mem_en=1, mem_wr=0 and mem_addr=base+2k.
REQ-026 Each word k SHALL be returned LATENCY cycles after issue k.
  - Return outputs: fill_data=mem_rdata, fill_idx=k, and the owner's data_valid=1.
  - Tracking uses an internal issue-tag delay line of depth LATENCY, holding valid, owner and idx.
REQ-027 The done pulse SHALL coincide with the return of word 7; the state returns to IDLE on the following edge.
REQ-028 Timing from the grant edge: issue occupies cycles 0..7, words return in cycles LATENCY..LATENCY+7, and done occurs at cycle LATENCY+7.
REQ-029 No new grant SHALL occur until the state is back in IDLE, so the next grant is at cycle LATENCY+8 at the earliest.
REQ-030 When no read is issued, mem_en SHALL be 0 and mem_wr SHALL be 0.
REQ-031 When not returning a word, data_valid SHALL be 0; fill_data and fill_idx are don't-care when data_valid is 0.
REQ-032 i_busy SHALL be high from the grant cycle through the done cycle of I_FILL; d_busy SHALL behave the same for D_WRITE and D_FILL.
REQ-033 A request dropped mid-transaction SHALL NOT abort it: all 8 words are still returned and done still pulses.
REQ-034 A request still asserted on the cycle after its done SHALL be treated as a new request.
REQ-035 Address arithmetic SHALL be 16-bit; since base is 16-aligned, base+14 cannot wrap (block 16'hFFF0 reads up to 16'hFFFE).
REQ-036 A d_req that arrives during I_FILL SHALL wait; it SHALL be granted on the first IDLE cycle, ahead of any pending i_req.

Reset
REQ-037 When rst_n=0, the state SHALL go to IDLE asynchronously and the delay line SHALL be cleared.
REQ-038 While rst_n=0, every output SHALL be 0.
REQ-039 Reset in the middle of a transaction SHALL discard all in-flight reads: no data_valid or done SHALL follow from them after rst_n rises.
REQ-040 The first grant after reset SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-041 I-fill with LATENCY=4: i_req=1, i_addr=16'h1236 ->
  - mem_addr 16'h1230..16'h123E on cycles 0..7;
  - i_data_valid with fill_idx 0..7 on cycles 4..11;
  - i_done at cycle 11.
REQ-042 Simultaneous request: i_req=1, d_req=1, d_wr=0, d_addr=16'h0040 in the same cycle ->
  - D_FILL is granted first, with d_done at cycle 11;
  - I_FILL is granted at cycle 12.
REQ-043 Write: d_req=1, d_wr=1, d_addr=16'h0100, d_wdata=16'hBEEF ->
  - a single cycle with mem_en=1, mem_wr=1, mem_addr=16'h0100, mem_wdata=16'hBEEF;
  - d_done pulses in that cycle.
REQ-044 Request dropped: i_req drops at cycle 2 of an I_FILL -> all 8 i_data_valid beats still occur and i_done still pulses.
REQ-045 Reset mid-fill: rst_n pulled low at cycle 6 of a fill ->
  - all outputs go to 0 immediately;
  - after release, no stale data_valid or done appears.
REQ-046 Top block: d_addr=16'hFFFA fill -> mem_addr 16'hFFF0..16'hFFFE, with no wrap.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory arbiter: grants D-side writes/fills and I-side fills onto one port.
// Reads are tracked by a tag delay line matching the fixed memory latency.
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_idx,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic        i_busy,
  output logic        d_busy,
  output logic        i_done,
  output logic        d_done
);

  localparam logic [2:0] LAST = 3'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    D_WRITE,
    D_FILL,
    I_FILL
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_base;
  logic [3:0]    r_cnt;
  logic [LATENCY-1:0] r_tv;
  logic [LATENCY-1:0] r_to;
  logic [2:0]    r_ti [LATENCY];

  logic          w_fill;
  logic          w_issue;
  logic          w_ret_v;
  logic          w_ret_i;
  logic [2:0]    w_ret_idx;
  logic          w_last;
  logic          w_wr;

  assign w_fill    = (r_state == D_FILL) || (r_state == I_FILL);
  assign w_issue   = w_fill && !r_cnt[3];
  assign w_wr      = (r_state == D_WRITE);
  assign w_ret_v   = r_tv[LATENCY-1];
  assign w_ret_i   = r_to[LATENCY-1];
  assign w_ret_idx = r_ti[LATENCY-1];
  assign w_last    = w_ret_v && (w_ret_idx == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Grant priority in IDLE; fills end with the last returned word
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (d_req && d_wr)  w_next = D_WRITE;
        else if (d_req)     w_next = D_FILL;
        else if (i_req)     w_next = I_FILL;
      end
      D_WRITE: w_next = IDLE;
      D_FILL:  if (w_last) w_next = IDLE;
      I_FILL:  if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Block base latched at grant; issue counter runs through the fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_cnt  <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
      if (d_req)      r_base <= d_addr & 16'hFFF0;
      else if (i_req) r_base <= i_addr & 16'hFFF0;
    end else if (w_issue) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Issue-tag delay line: valid, owner (1 = I-side), word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tv <= '0;
      r_to <= '0;
      for (int i = 0; i < LATENCY; i++) r_ti[i] <= '0;
    end else begin
      r_tv[0] <= w_issue;
      r_to[0] <= (r_state == I_FILL);
      r_ti[0] <= r_cnt[2:0];
      for (int i = 1; i < LATENCY; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_to[i] <= r_to[i-1];
        r_ti[i] <= r_ti[i-1];
      end
    end
  end

  // Memory port, return path and status outputs
  always_comb begin
    mem_en    = w_issue || w_wr;
    mem_wr    = w_wr;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_wr) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_issue) begin
      mem_addr = r_base + {12'd0, r_cnt[2:0], 1'b0};
    end
    fill_data    = w_ret_v ? mem_rdata : '0;
    fill_idx     = w_ret_v ? w_ret_idx : '0;
    i_data_valid = w_ret_v && w_ret_i;
    d_data_valid = w_ret_v && !w_ret_i;
    i_done       = w_last && w_ret_i;
    d_done       = w_wr || (w_last && !w_ret_i);
    i_busy       = (r_state == I_FILL);
    d_busy       = w_wr || (r_state == D_FILL);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: planned accesses, returns and
// completions are queued by the stimulus and checked by a monitor.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] mem_rdata = '0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_idx;
  logic        i_data_valid, d_data_valid;
  logic        i_busy, d_busy, i_done, d_done;

  mem_arbiter #(.LATENCY(LAT), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_data_valid(i_data_valid),
    .d_data_valid(d_data_valid),
    .i_busy(i_busy), .d_busy(d_busy),
    .i_done(i_done), .d_done(d_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mexp_t;

  typedef struct {
    int          cyc;
    logic        own;
    logic [2:0]  idx;
    logic [15:0] data;
  } rexp_t;

  typedef struct {
    int   cyc;
    logic own;
  } dexp_t;

  mexp_t q_mem[$];
  rexp_t q_ret[$];
  dexp_t q_done[$];
  bit    exp_ib [0:4095];
  bit    exp_db [0:4095];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mdat(logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endfunction

  function automatic void miss(string nm, int c);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event for cyc %0d not seen (now %0d)",
             nm, c, cyc);
  endfunction

  // Memory model: read data appears LAT cycles after issue
  logic [16:0] rp [LAT];
  initial for (int i = 0; i < LAT; i++) rp[i] = '0;

  always @(negedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rp[i] = rp[i-1];
    rp[0] = {mem_en & ~mem_wr, mem_addr};
  end

  always begin
    @(posedge clk);
    #1;
    mem_rdata = rp[LAT-1][16] ? mdat(rp[LAT-1][15:0]) : 16'h0;
  end

  // Monitor: compares whatever the DUT presents against queue heads
  always @(negedge clk) begin
    mexp_t m;
    rexp_t r;
    dexp_t d;
    while (q_mem.size() > 0 && q_mem[0].cyc < cyc) begin
      miss("mem_missed", q_mem[0].cyc);
      void'(q_mem.pop_front());
    end
    while (q_ret.size() > 0 && q_ret[0].cyc < cyc) begin
      miss("ret_missed", q_ret[0].cyc);
      void'(q_ret.pop_front());
    end
    while (q_done.size() > 0 && q_done[0].cyc < cyc) begin
      miss("done_missed", q_done[0].cyc);
      void'(q_done.pop_front());
    end
    if (mem_en) begin
      if (q_mem.size() == 0) chk("mem_unexpected", 1, 0);
      else begin
        m = q_mem.pop_front();
        chk("mem_cyc", 64'(cyc), 64'(m.cyc));
        chk("mem_wr", mem_wr, m.wr);
        chk("mem_addr", mem_addr, m.addr);
        if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
      end
    end else begin
      chk("mem_wr_idle", mem_wr, 0);
    end
    if (i_data_valid || d_data_valid) begin
      if (q_ret.size() == 0) chk("ret_unexpected", 1, 0);
      else begin
        r = q_ret.pop_front();
        chk("ret_cyc", 64'(cyc), 64'(r.cyc));
        chk("ret_owner", {i_data_valid, d_data_valid},
            {r.own, ~r.own});
        chk("ret_idx", fill_idx, r.idx);
        chk("ret_data", fill_data, r.data);
      end
    end
    if (i_done || d_done) begin
      if (q_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        d = q_done.pop_front();
        chk("done_cyc", 64'(cyc), 64'(d.cyc));
        chk("done_owner", {i_done, d_done}, {d.own, ~d.own});
      end
    end
    if (cyc < 4096) begin
      chk("i_busy", i_busy, exp_ib[cyc]);
      chk("d_busy", d_busy, exp_db[cyc]);
    end
  end

  task automatic plan_fill(logic own, logic [15:0] a, int c0);
    logic [15:0] b;
    logic [15:0] w;
    b = a & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      w = b + 16'(2 * k);
      q_mem.push_back('{c0 + k, 1'b0, w, 16'h0});
      q_ret.push_back('{c0 + LAT + k, own, 3'(k), mdat(w)});
    end
    q_done.push_back('{c0 + LAT + 7, own});
    for (int c = c0; c <= c0 + LAT + 7; c++) begin
      if (own) exp_ib[c] = 1'b1;
      else     exp_db[c] = 1'b1;
    end
  endtask

  task automatic plan_write(logic [15:0] a, logic [15:0] wd, int c0);
    q_mem.push_back('{c0, 1'b1, a, wd});
    q_done.push_back('{c0, 1'b0});
    exp_db[c0] = 1'b1;
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_zero(string nm);
    chk(nm, {mem_en, mem_wr, mem_addr, mem_wdata, fill_data,
             fill_idx, i_data_valid, d_data_valid,
             i_busy, d_busy, i_done, d_done}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    #7;
    chk_zero("reset_outputs");
    repeat (3) @(negedge clk);

    // I-fill granted on the first edge after reset release
    rst_n  = 1'b1;
    i_req  = 1'b1;
    i_addr = 16'h1236;
    c0 = cyc + 1;
    plan_fill(1'b1, 16'h1236, c0);
    wait_to(c0 + LAT + 7);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous D fill and I fill: D first
    i_req  = 1'b1;
    i_addr = 16'h2008;
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h0040;
    c0 = cyc + 1;
    plan_fill(1'b0, 16'h0040, c0);
    plan_fill(1'b1, 16'h2008, c0 + LAT + 9);
    wait_to(c0 + LAT + 7);
    d_req = 1'b0;
    wait_to(c0 + 2 * LAT + 16);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    // Single-word write-through
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 16'h0100;
    d_wdata = 16'hBEEF;
    c0 = cyc + 1;
    plan_write(16'h0100, 16'hBEEF, c0);
    wait_to(c0);
    d_req = 1'b0;
    d_wr  = 1'b0;
    repeat (2) @(negedge clk);

    // Request dropped mid-fill, address changed after grant
    i_req  = 1'b1;
    i_addr = 16'h345A;
    c0 = cyc + 1;
    plan_fill(1'b1, 16'h345A, c0);
    wait_to(c0 + 1);
    i_addr = 16'h7777;
    wait_to(c0 + 2);
    i_req = 1'b0;
    wait_to(c0 + LAT + 9);

    // Reset in the middle of a D fill
    d_req  = 1'b1;
    d_addr = 16'h5554;
    c0 = cyc + 1;
    plan_fill(1'b0, 16'h5554, c0);
    wait_to(c0 + 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midfill_reset_outputs");
    q_mem.delete();
    q_ret.delete();
    q_done.delete();
    for (int c = c0 + 7; c <= c0 + LAT + 8; c++) exp_db[c] = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Top block, no address wrap
    d_req  = 1'b1;
    d_addr = 16'hFFFA;
    c0 = cyc + 1;
    plan_fill(1'b0, 16'hFFFA, c0);
    wait_to(c0 + LAT + 7);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Request held past done is a new request
    i_req  = 1'b1;
    i_addr = 16'h0884;
    c0 = cyc + 1;
    c1 = c0 + LAT + 9;
    plan_fill(1'b1, 16'h0884, c0);
    plan_fill(1'b1, 16'h0884, c1);
    wait_to(c1 + LAT + 7);
    i_req = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    chk("mem_queue_empty", q_mem.size(), 0);
    chk("ret_queue_empty", q_ret.size(), 0);
    chk("done_queue_empty", q_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
